// File: rtl/stoch_signed_pool_unit_pkg.sv
// Shared types and helpers for the signed stochastic pooling unit.
// Pure functions only; no state, no latency, no flow control.
package stoch_pool_pkg;

    typedef enum logic [0:0] {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

    // Bipolar step: p alone counts up, m alone counts down, clamped to the signed range of width bits.
    function automatic logic signed [31:0] sat_step(input logic signed [31:0] cnt,
                                                   input logic p,
                                                   input logic m,
                                                   input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (p && !m && (cnt < hi)) return cnt + 32'sd1;
        if (m && !p && (cnt > lo)) return cnt - 32'sd1;
        return cnt;
    endfunction

endpackage

// File: rtl/stoch_signed_pool_unit_if.sv
// Pooling window bus: bipolar input streams, enable/clear and pooled outputs with select index.
// Combinational wiring only; the consumer never stalls the producer.
interface stoch_signed_pool_unit_if
    import stoch_pool_pkg::*;
#(
    parameter int NUM_INPUTS = 9,
    parameter int CHANNELS   = 3
);
    localparam int SEL_W = sel_width(NUM_INPUTS);

    logic                                 en;
    logic                                 clr;
    logic [CHANNELS-1:0][NUM_INPUTS-1:0]  as_p;
    logic [CHANNELS-1:0][NUM_INPUTS-1:0]  as_m;
    logic [CHANNELS-1:0]                  y_p;
    logic [CHANNELS-1:0]                  y_m;
    logic [CHANNELS-1:0][SEL_W-1:0]       sel;

    modport master (output en, clr, as_p, as_m, input y_p, y_m, sel);
    modport slave  (input en, clr, as_p, as_m, output y_p, y_m, sel);
endinterface

// File: rtl/stoch_signed_pool_unit_sat_counter.sv
// One saturating bipolar up/down counter; updates one edge after p/m, holds when en is low.
// No backpressure: clr wins over en, reset wins over both.
module stoch_signed_sat_counter
    import stoch_pool_pkg::*;
#(
    parameter int CNT_W = 6
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    p,
    input  logic                    m,
    output logic signed [CNT_W-1:0] cnt
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(sat_step(32'(cnt), p, m, CNT_W));
        end
    end
endmodule

// File: rtl/stoch_signed_pool_unit.sv
// Signed stochastic max/avg pooling per channel; sel lags dominance by 1 edge, y by 2 edges.
// No backpressure (en gates all state). Optional select hysteresis under STOCH_POOL_HYST_EN.
module stoch_signed_pool_unit
    import stoch_pool_pkg::*;
#(
    parameter int NUM_INPUTS = 9,
    parameter int CHANNELS   = 3,
    parameter int CNT_W      = 6,
    parameter int MODE       = 0,
    parameter int HYST       = 2
)(
    input  logic                    CLK,
    input  logic                    RST,
    stoch_signed_pool_unit_if.slave bus
);
    localparam int              SEL_W = sel_width(NUM_INPUTS);
    localparam bit              AVG   = (MODE == int'(POOL_AVG));
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INPUTS - 1);

    logic signed [CNT_W-1:0]        cnt [CHANNELS][NUM_INPUTS];
    logic [CHANNELS-1:0][SEL_W-1:0] sel_q;
    logic [CHANNELS-1:0][SEL_W-1:0] sel_d;
    logic [CHANNELS-1:0][SEL_W-1:0] src;
    logic [SEL_W-1:0]               rr_q;
    logic [SEL_W-1:0]               rr_nxt;
    logic [CHANNELS-1:0]            y_p_q;
    logic [CHANNELS-1:0]            y_m_q;

    if (!AVG) begin : g_max
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
                stoch_signed_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                    .CLK (CLK),
                    .RST (RST),
                    .en  (bus.en),
                    .clr (bus.clr),
                    .p   (bus.as_p[c][i]),
                    .m   (bus.as_m[c][i]),
                    .cnt (cnt[c][i])
                );
            end
        end
    end else begin : g_avg
        always_comb begin
            for (int c = 0; c < CHANNELS; c++)
                for (int i = 0; i < NUM_INPUTS; i++)
                    cnt[c][i] = '0;
        end
    end

    always_comb begin
        logic [SEL_W-1:0]        best;
        logic signed [CNT_W:0]   cand_ext;
        logic signed [CNT_W:0]   thr;
        rr_nxt   = (rr_q == LAST) ? '0 : rr_q + 1'b1;
        sel_d    = sel_q;
        src      = sel_q;
        best     = '0;
        cand_ext = '0;
        thr      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // Strict compare keeps the lowest index on ties.
            best = '0;
            for (int i = 1; i < NUM_INPUTS; i++)
                if (cnt[c][i] > cnt[c][best]) best = SEL_W'(i);
            if (AVG) begin
                sel_d[c] = rr_nxt;
                src[c]   = rr_q;
            end else begin
`ifdef STOCH_POOL_HYST_EN
                // One extra bit so the current count plus margin cannot overflow.
                cand_ext = {cnt[c][best][CNT_W-1], cnt[c][best]};
                thr      = {cnt[c][sel_q[c]][CNT_W-1], cnt[c][sel_q[c]]} + (CNT_W+1)'(HYST);
                sel_d[c] = (cand_ext > thr) ? best : sel_q[c];
`else
                sel_d[c] = best;
`endif
                src[c] = sel_q[c];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q <= '0;
            rr_q  <= '0;
            y_p_q <= '0;
            y_m_q <= '0;
        end else if (bus.clr) begin
            sel_q <= '0;
            rr_q  <= '0;
            y_p_q <= '0;
            y_m_q <= '0;
        end else if (bus.en) begin
            sel_q <= sel_d;
            rr_q  <= rr_nxt;
            for (int c = 0; c < CHANNELS; c++) begin
                y_p_q[c] <= bus.as_p[c][src[c]];
                y_m_q[c] <= bus.as_m[c][src[c]];
            end
        end
    end

    assign bus.sel = sel_q;
    assign bus.y_p = y_p_q;
    assign bus.y_m = y_m_q;
endmodule

// File: tb/tb_stoch_signed_pool_unit.sv
// Directed bench for max and average pooling instances with hand-derived expectations.
module tb_stoch_signed_pool_unit;
    localparam int NI = 4;
    localparam int CH = 2;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    stoch_signed_pool_unit_if #(.NUM_INPUTS(NI), .CHANNELS(CH)) bm ();
    stoch_signed_pool_unit_if #(.NUM_INPUTS(NI), .CHANNELS(CH)) ba ();

    stoch_signed_pool_unit #(.NUM_INPUTS(NI), .CHANNELS(CH), .CNT_W(CW), .MODE(0), .HYST(2)) u_max (
        .CLK (CLK), .RST (RST), .bus (bm.slave));
    stoch_signed_pool_unit #(.NUM_INPUTS(NI), .CHANNELS(CH), .CNT_W(CW), .MODE(1), .HYST(2)) u_avg (
        .CLK (CLK), .RST (RST), .bus (ba.slave));

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        bm.en = 1'b0; bm.clr = 1'b0; bm.as_p = '0; bm.as_m = '0;
        ba.en = 1'b0; ba.clr = 1'b0; ba.as_p = '0; ba.as_m = '0;
        #2;
        chk("rst_sel0", int'(bm.sel[0]), 0);
        chk("rst_y_p", int'(bm.y_p), 0);
        chk("rst_cnt", int'(u_max.cnt[0][0]), 0);
        step(2);
        RST = 1'b0;

        // dominance on ch0 input 2
        bm.as_p[0][2] = 1'b1;
        bm.en = 1'b1;
        step(1);
        chk("max_e1_cnt2", int'(u_max.cnt[0][2]), 1);
        chk("max_e1_sel", int'(bm.sel[0]), 0);
        step(1);
        chk("max_e2_sel", int'(bm.sel[0]), 2);
        chk("max_e2_y_p", int'(bm.y_p[0]), 0);
        step(1);
        chk("max_e3_y_p", int'(bm.y_p[0]), 1);
        chk("max_e3_y_m", int'(bm.y_m[0]), 0);
        chk("max_e3_cnt2", int'(u_max.cnt[0][2]), 3);

        // asynchronous reset mid-stream
        RST = 1'b1;
        #1;
        chk("mrst_y_p", int'(bm.y_p), 0);
        chk("mrst_sel0", int'(bm.sel[0]), 0);
        chk("mrst_sel1", int'(bm.sel[1]), 0);
        RST = 1'b0;
        bm.as_p = '0;
        #1;
        chk("mrst_cnt2", int'(u_max.cnt[0][2]), 0);

        // saturation up then down on ch1 input 0
        bm.as_p[1][0] = 1'b1;
        step(20);
        chk("sat_hi", int'(u_max.cnt[1][0]), 7);
        bm.as_p[1][0] = 1'b0;
        bm.as_m[1][0] = 1'b1;
        step(1);
        chk("sat_hi_m1", int'(u_max.cnt[1][0]), 6);
        step(19);
        chk("sat_lo", int'(u_max.cnt[1][0]), -8);
        chk("sat_lo_other", int'(u_max.cnt[1][1]), 0);

        // clear, then tie between inputs 1 and 3 on ch0
        bm.as_m = '0;
        bm.clr = 1'b1;
        step(1);
        bm.clr = 1'b0;
        chk("clr_cnt10", int'(u_max.cnt[1][0]), 0);
        bm.as_p[0] = 4'b1010;
        step(2);
        chk("tie_sel", int'(bm.sel[0]), 1);
        chk("tie_ch1_sel", int'(bm.sel[1]), 0);
        step(1);
        chk("tie_y_p", int'(bm.y_p[0]), 1);
        chk("tie_cnt3", int'(u_max.cnt[0][3]), 3);
        bm.clr = 1'b1;
        step(1);
        bm.clr = 1'b0;
        bm.as_p = '0;
        chk("clr_cnt1", int'(u_max.cnt[0][1]), 0);
        chk("clr_cnt3", int'(u_max.cnt[0][3]), 0);
        chk("clr_sel", int'(bm.sel[0]), 0);
        chk("clr_y_p", int'(bm.y_p[0]), 0);

        // hold with en low and toggling inputs
        bm.as_p[0] = 4'b0100;
        step(4);
        chk("pre_hold_cnt2", int'(u_max.cnt[0][2]), 4);
        chk("pre_hold_sel", int'(bm.sel[0]), 2);
        chk("pre_hold_y_p", int'(bm.y_p[0]), 1);
        bm.en = 1'b0;
        repeat (5) begin
            bm.as_p = 8'($urandom);
            bm.as_m = 8'($urandom);
            step(1);
        end
        chk("hold_cnt2", int'(u_max.cnt[0][2]), 4);
        chk("hold_sel", int'(bm.sel[0]), 2);
        chk("hold_y_p", int'(bm.y_p[0]), 1);
        chk("hold_y_m", int'(bm.y_m[0]), 0);

        // average pooling: round-robin over the window
        ba.as_p[0] = 4'b0101;
        ba.as_p[1] = 4'b0011;
        ba.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("avg_y_p0", int'(ba.y_p[0]), (k % 2 == 0) ? 1 : 0);
            chk("avg_y_p1", int'(ba.y_p[1]), ((k % 4) < 2) ? 1 : 0);
            chk("avg_sel", int'(ba.sel[0]), (k + 1) % 4);
        end
        ba.en = 1'b0;

        // select switching margin
        bm.as_p = '0;
        bm.as_m = '0;
        bm.en = 1'b1;
        bm.clr = 1'b1;
        step(1);
        bm.clr = 1'b0;
        bm.as_p[0][1] = 1'b1;
`ifdef STOCH_POOL_HYST_EN
        step(3);
        chk("hyst_lead2", int'(bm.sel[0]), 0);
        step(1);
        chk("hyst_lead3", int'(bm.sel[0]), 1);
`else
        step(1);
        chk("nohyst_e1", int'(bm.sel[0]), 0);
        step(1);
        chk("nohyst_e2", int'(bm.sel[0]), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
